// File: rtl/gpo_timed_pkg.sv
// gpo_timed_pkg: shared definitions for the timed general-purpose output block.
//   - Register offsets relative to BASE_ADDR on the 8-bit CSR bus.
//   - One-shot pulse engine state encoding.
package gpo_timed_pkg;

    localparam logic [2:0] REG_OUT   = 3'd0;
    localparam logic [2:0] REG_BLINK = 3'd1;
    localparam logic [2:0] REG_RATE  = 3'd2;
    localparam logic [2:0] REG_PULSE = 3'd3;
    localparam logic [2:0] REG_PLEN  = 3'd4;

    typedef enum logic {
        PULSE_IDLE = 1'b0,
        PULSE_BUSY = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/gpo_pulse.sv
// gpo_pulse: per-pin one-shot engine with an 8-bit tick down-counter.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   tick    in   shared timing tick, one clock wide
//   trigger in   start / restart request (ignored when plen is 0)
//   plen    in   pulse length in ticks
//   busy    out  high while the one-shot is running
module gpo_pulse
    import gpo_timed_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       trigger,
    input  logic [7:0] plen,
    output logic       busy
);

    pulse_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A trigger beats the tick, so a retrigger on the final tick keeps the pin busy.
        if (trigger && (plen != 8'd0)) begin
            state_d = PULSE_BUSY;
            cnt_d   = plen;
        end else if ((state_q == PULSE_BUSY) && tick) begin
            if (cnt_q == 8'd1) begin
                state_d = PULSE_IDLE;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PULSE_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == PULSE_BUSY);

endmodule

// File: rtl/gpo_timed.sv
// gpo_timed: output-only GPIO block with static level, blink and one-shot pulse.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   csr_a   in   CSR address (5 bits)
//   csr_di  in   CSR write data
//   csr_we  in   CSR write strobe, acts at the clk edge where it is high
//   csr_do  out  CSR read data, combinational
//   out     out  registered pin drive, NUM_GPIOS wide
// Registers at BASE_ADDR+: 0 OUT, 1 BLINK, 2 RATE, 3 PULSE (w: trigger, r: busy), 4 PLEN.
module gpo_timed
    import gpo_timed_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'h00,
    parameter int         NUM_GPIOS = 8,
    parameter int         TICK_DIV  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           csr_a,
    input  logic [7:0]           csr_di,
    input  logic                 csr_we,
    output logic [7:0]           csr_do,
    output logic [NUM_GPIOS-1:0] out
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [NUM_GPIOS-1:0] out_reg_q, out_reg_d;
    logic [NUM_GPIOS-1:0] blink_q, blink_d;
    logic [7:0]           rate_q, rate_d;
    logic [7:0]           plen_q, plen_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [7:0]           bcnt_q, bcnt_d;
    logic                 phase_q, phase_d;
    logic [NUM_GPIOS-1:0] pin_q, pin_d;

    logic [4:0]           off;
    logic                 hit;
    logic                 we_out, we_blink, we_rate, we_pulse, we_plen;
    logic                 tick;
    logic [NUM_GPIOS-1:0] trig;
    logic [NUM_GPIOS-1:0] busy;

    // Address decode; BASE_ADDR+4 fits in 5 bits so the subtraction cannot wrap on a hit.
    assign off      = csr_a - BASE_ADDR;
    assign hit      = (csr_a >= BASE_ADDR) && (off <= 5'd4);
    assign we_out   = csr_we && hit && (off[2:0] == REG_OUT);
    assign we_blink = csr_we && hit && (off[2:0] == REG_BLINK);
    assign we_rate  = csr_we && hit && (off[2:0] == REG_RATE);
    assign we_pulse = csr_we && hit && (off[2:0] == REG_PULSE);
    assign we_plen  = csr_we && hit && (off[2:0] == REG_PLEN);

    assign tick = (presc_q == PRESC_LAST);
    assign trig = we_pulse ? csr_di[NUM_GPIOS-1:0] : '0;

    for (genvar i = 0; i < NUM_GPIOS; i++) begin : g_pulse
        gpo_pulse u_pulse (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .trigger (trig[i]),
            .plen    (plen_q),
            .busy    (busy[i])
        );
    end

    always_comb begin
        out_reg_d = we_out   ? csr_di[NUM_GPIOS-1:0] : out_reg_q;
        blink_d   = we_blink ? csr_di[NUM_GPIOS-1:0] : blink_q;
        plen_d    = we_plen  ? csr_di : plen_q;
        rate_d    = rate_q;
        presc_d   = tick ? '0 : presc_q + PW'(1);
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
        if (tick) begin
            if (bcnt_q == rate_q) begin
                bcnt_d  = 8'd0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 8'd1;
            end
        end
        // A RATE write realigns the whole blink timebase so the new half-period starts cleanly.
        if (we_rate) begin
            rate_d  = csr_di;
            presc_d = '0;
            bcnt_d  = 8'd0;
            phase_d = 1'b0;
        end
        pin_d = out_reg_q ^ (blink_q & {NUM_GPIOS{phase_q}}) ^ busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg_q <= '0;
            blink_q   <= '0;
            rate_q    <= 8'd0;
            plen_q    <= 8'd0;
            presc_q   <= '0;
            bcnt_q    <= 8'd0;
            phase_q   <= 1'b0;
            pin_q     <= '0;
        end else begin
            out_reg_q <= out_reg_d;
            blink_q   <= blink_d;
            rate_q    <= rate_d;
            plen_q    <= plen_d;
            presc_q   <= presc_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            pin_q     <= pin_d;
        end
    end

    always_comb begin
        csr_do = 8'd0;
        if (hit) begin
            case (off[2:0])
                REG_OUT:   csr_do = 8'(out_reg_q);
                REG_BLINK: csr_do = 8'(blink_q);
                REG_RATE:  csr_do = rate_q;
                REG_PULSE: csr_do = 8'(busy);
                REG_PLEN:  csr_do = plen_q;
                default:   csr_do = 8'd0;
            endcase
        end
    end

    assign out = pin_q;

endmodule

// File: tb/tb_gpo_timed.sv
// tb_gpo_timed: directed bench for gpo_timed with TICK_DIV=4, BASE_ADDR=5'h10.
// The reference model describes outputs by edge arithmetic: ticks fall every D
// edges after the last timebase restart, phase is the parity of elapsed
// half-periods, and each pulse is an interval [trigger edge, end edge).
module tb_gpo_timed;

    localparam int         D    = 4;
    localparam logic [4:0] BASE = 5'h10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] csr_a = 5'd0;
    logic [7:0] csr_di = 8'd0;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic [7:0] dut_out;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    gpo_timed #(.BASE_ADDR(BASE), .NUM_GPIOS(8), .TICK_DIV(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .csr_a  (csr_a),
        .csr_di (csr_di),
        .csr_we (csr_we),
        .csr_do (csr_do),
        .out    (dut_out)
    );

    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    longint     e_cnt = 0;
    longint     rate_edge = 0;
    longint     pend [8];
    logic [7:0] m_out = 8'd0, m_blink = 8'd0, m_rate = 8'd0, m_plen = 8'd0, m_pin = 8'd0;

    function automatic bit m_phase(input longint x);
        longint half;
        half = (longint'(m_rate) + 1) * D;
        return (((x - rate_edge) / half) % 2) == 1;
    endfunction

    function automatic logic [7:0] m_busy(input longint x);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (x < pend[i]);
        return b;
    endfunction

    function automatic longint next_tick(input longint x);
        return rate_edge + ((x - rate_edge) / D + 1) * D;
    endfunction

    function automatic logic [7:0] m_read(input logic [4:0] a);
        if (a < BASE || a > BASE + 5'd4) return 8'd0;
        case (a - BASE)
            5'd0: return m_out;
            5'd1: return m_blink;
            5'd2: return m_rate;
            5'd3: return m_busy(e_cnt);
            default: return m_plen;
        endcase
    endfunction

    initial for (int i = 0; i < 8; i++) pend[i] = 0;

    always @(posedge clk) begin
        e_cnt = e_cnt + 1;
        if (rst) begin
            m_out = 0; m_blink = 0; m_rate = 0; m_plen = 0; m_pin = 0;
            rate_edge = e_cnt;
            for (int i = 0; i < 8; i++) pend[i] = 0;
        end else begin
            m_pin = m_out ^ (m_blink & {8{m_phase(e_cnt - 1)}}) ^ m_busy(e_cnt - 1);
            if (csr_we && csr_a >= BASE && csr_a <= BASE + 5'd4) begin
                case (csr_a - BASE)
                    5'd0: m_out = csr_di;
                    5'd1: m_blink = csr_di;
                    5'd2: begin m_rate = csr_di; rate_edge = e_cnt; end
                    5'd3: for (int i = 0; i < 8; i++)
                              if (csr_di[i] && m_plen != 0)
                                  pend[i] = next_tick(e_cnt) + (longint'(m_plen) - 1) * D;
                    default: m_plen = csr_di;
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out", dut_out, m_pin);
            check("model_csr_do", csr_do, m_read(csr_a));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        csr_a = a; csr_di = d; csr_we = 1'b1;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic rd_now(input logic [4:0] a, output logic [7:0] d);
        csr_a = a;
        #1;
        d = csr_do;
    endtask

    task automatic wait_level(input int b, input logic lvl, output int k);
        k = 0;
        while (dut_out[b] !== lvl && k < 40) begin
            step(1);
            k++;
        end
    endtask

    logic [7:0] r;
    int k, hi;

    initial begin
        step(3);
        chk_en = 1'b1;
        rst = 1'b0;

        // reset state and decode
        check("rst_out", dut_out, 8'h00);
        for (int a = 0; a < 5; a++) begin
            rd_now(BASE + 5'(a), r);
            check("rst_reg", r, 8'h00);
        end
        wr(BASE + 5'd5, 8'hFF);
        rd_now(BASE + 5'd5, r);
        check("unmapped_rd", r, 8'h00);
        rd_now(BASE, r);
        check("unmapped_wr_out", r, 8'h00);

        // static level with one cycle of pin latency
        wr(BASE + 5'd0, 8'hA5);
        rd_now(BASE + 5'd0, r);
        check("static_rd", r, 8'hA5);
        check("static_lat", dut_out, 8'h00);
        step(1);
        check("static_out", dut_out, 8'hA5);
        wr(BASE + 5'd0, 8'h00);

        // blink: RATE=1 gives 8-clock half-period
        wr(BASE + 5'd1, 8'h01);
        wr(BASE + 5'd2, 8'h01);
        wait_level(0, 1'b1, k);
        check("blink_first", 8'(k), 8'd9);
        wait_level(0, 1'b0, k);
        check("blink_period0", 8'(k), 8'd8);
        wait_level(0, 1'b1, k);
        check("blink_period1", 8'(k), 8'd8);
        wr(BASE + 5'd2, 8'h01);
        wait_level(0, 1'b0, k);
        check("blink_restart_clr", 8'(k), 8'd1);
        wait_level(0, 1'b1, k);
        check("blink_restart_per", 8'(k), 8'd8);
        check("blink_others", dut_out & 8'hFE, 8'h00);
        wr(BASE + 5'd1, 8'h00);
        step(2);

        // single pulse, PLEN=3
        wr(BASE + 5'd4, 8'd3);
        wr(BASE + 5'd3, 8'h02);
        rd_now(BASE + 5'd3, r);
        check("pulse_busy_rd", r, 8'h02);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (dut_out[1]) hi++;
        end
        total++;
        if (hi < 9 || hi > 12) begin
            bad++;
            $display("FAIL pulse_len: got %0d clocks expected 9..12", hi);
        end
        check("pulse_end_out", dut_out, 8'h00);
        rd_now(BASE + 5'd3, r);
        check("pulse_end_rd", r, 8'h00);

        // PLEN=0 trigger is ignored
        wr(BASE + 5'd4, 8'd0);
        wr(BASE + 5'd3, 8'h04);
        rd_now(BASE + 5'd3, r);
        check("plen0_rd", r, 8'h00);
        step(2);
        check("plen0_out", dut_out, 8'h00);

        // retrigger extends the pulse
        wr(BASE + 5'd4, 8'd2);
        wr(BASE + 5'd3, 8'h01);
        step(3);
        wr(BASE + 5'd3, 8'h01);
        step(5);
        check("retrig_ext", dut_out & 8'h01, 8'h01);
        step(10);
        check("retrig_done", dut_out, 8'h00);

        // combined blink and pulse, with a base-level write mid-pulse
        wr(BASE + 5'd2, 8'd0);
        wr(BASE + 5'd1, 8'h01);
        wr(BASE + 5'd4, 8'd3);
        wr(BASE + 5'd3, 8'h01);
        step(3);
        wr(BASE + 5'd0, 8'h81);
        step(20);

        // reset during active pulse and blink
        wr(BASE + 5'd3, 8'h03);
        step(1);
        rst = 1'b1;
        step(1);
        check("rst_mid_out", dut_out, 8'h00);
        for (int a = 0; a < 5; a++) begin
            rd_now(BASE + 5'(a), r);
            check("rst_mid_reg", r, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        step(20);
        check("rst_after_out", dut_out, 8'h00);
        rd_now(BASE + 5'd3, r);
        check("rst_after_busy", r, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
